// File: rtl/piano_pkg.sv
// Shared types and constants for the piano key front end.
// Used by the display and tone blocks as well.
package piano_pkg;

  localparam int OCT_W = 3;
  localparam int NKEY  = 7;

  typedef logic [2:0] note_t;

  localparam note_t NOTE_NONE = 3'd0;
  localparam note_t NOTE_A    = 3'd1;
  localparam note_t NOTE_B    = 3'd2;
  localparam note_t NOTE_C    = 3'd3;
  localparam note_t NOTE_D    = 3'd4;
  localparam note_t NOTE_E    = 3'd5;
  localparam note_t NOTE_F    = 3'd6;
  localparam note_t NOTE_G    = 3'd7;

  // Lowest key index wins when several keys are down.
  function automatic note_t note_enc(
    input logic [NKEY-1:0] k
  );
    note_t n;
    n = NOTE_NONE;
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (k[i]) n = note_t'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a counting debouncer
// for one raw asynchronous input.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/piano_key_frontend.sv
// Piano input front end: debounced keys to a registered note code,
// octave buttons to a saturating octave register, with event strobes.
module piano_key_frontend
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OCT_MIN         = 0,
  parameter int OCT_MAX         = 7,
  parameter int OCT_RESET       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       key,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [2:0]       note,
  output logic             note_valid,
  output logic             note_on,
  output logic [OCT_W-1:0] octave,
  output logic             oct_chg
);

  localparam logic [OCT_W-1:0] OMIN = OCT_W'(OCT_MIN);
  localparam logic [OCT_W-1:0] OMAX = OCT_W'(OCT_MAX);
  localparam logic [OCT_W-1:0] ORST = OCT_W'(OCT_RESET);

  logic [8:0] raw;
  logic [8:0] db;

  assign raw = {btn_down, btn_up, key};

  for (genvar i = 0; i < 9; i++) begin : g_db
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .db   (db[i])
    );
  end

  note_t            enc;
  logic             up_q;
  logic             dn_q;
  logic             up_e;
  logic             dn_e;
  logic [OCT_W-1:0] oct_nx;

  assign enc  = note_enc(db[6:0]);
  assign up_e = db[7] & ~up_q;
  assign dn_e = db[8] & ~dn_q;

  // Simultaneous up and down edges cancel.
  always_comb begin
    oct_nx = octave;
    unique case ({up_e, dn_e})
      2'b10: if (octave != OMAX) oct_nx = octave + OCT_W'(1);
      2'b01: if (octave != OMIN) oct_nx = octave - OCT_W'(1);
      default: oct_nx = octave;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note       <= NOTE_NONE;
      note_valid <= 1'b0;
      note_on    <= 1'b0;
      octave     <= ORST;
      oct_chg    <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
    end else begin
      note       <= enc;
      note_valid <= (enc != NOTE_NONE);
      note_on    <= (enc != NOTE_NONE) && (enc != note);
      octave     <= oct_nx;
      oct_chg    <= (oct_nx != octave);
      up_q       <= db[7];
      dn_q       <= db[8];
    end
  end

endmodule

// File: tb/tb_piano_key_frontend.sv
// Self-checking bench for piano_key_frontend with DEBOUNCE_CYCLES=4.
// Vector table plus hand sequences for latency, bounce and reset.
module tb_piano_key_frontend;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] key = '0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [2:0] note;
  logic       note_valid;
  logic       note_on;
  logic [2:0] octave;
  logic       oct_chg;

  piano_key_frontend #(
    .DEBOUNCE_CYCLES(4),
    .OCT_MIN(0),
    .OCT_MAX(7),
    .OCT_RESET(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .note      (note),
    .note_valid(note_valid),
    .note_on   (note_on),
    .octave    (octave),
    .oct_chg   (oct_chg)
  );

  always #5 clk = ~clk;

  int on_cnt = 0;
  int chg_cnt = 0;

  always @(negedge clk) begin
    if (note_on) on_cnt++;
    if (oct_chg) chg_cnt++;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [6:0] key;
    logic       up;
    logic       dn;
    int         hold;
    int         note;
    int         oct;
    int         ons;
    int         chgs;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   cur_oct;

  task automatic add(input logic [6:0] k, input logic u, input logic d,
                     input int h, input int n, input int o,
                     input int ons, input int chgs);
    vec_t v;
    v.key = k; v.up = u; v.dn = d; v.hold = h;
    v.note = n; v.oct = o; v.ons = ons; v.chgs = chgs;
    tbl.push_back(v);
  endtask

  task automatic add_step(input logic u, input logic d);
    int nx;
    nx = cur_oct;
    if (u && !d && cur_oct < 7) nx = cur_oct + 1;
    if (d && !u && cur_oct > 0) nx = cur_oct - 1;
    add(7'd0, u, d, 12, 0, nx, 0, (nx != cur_oct) ? 1 : 0);
    add(7'd0, 1'b0, 1'b0, 12, 0, nx, 0, 0);
    cur_oct = nx;
  endtask

  initial begin
    vec_t e;
    int b_on;
    int b_chg;

    cur_oct = 4;
    add(7'b0000000, 0, 0, 12, 0, 4, 0, 0);
    add(7'b0000100, 0, 0, 20, 3, 4, 1, 0);
    add(7'b0000000, 0, 0, 12, 0, 4, 0, 0);
    add(7'b0010000, 0, 0, 12, 5, 4, 1, 0);
    add(7'b0010010, 0, 0, 12, 2, 4, 1, 0);
    add(7'b0010000, 0, 0, 12, 5, 4, 1, 0);
    add(7'b0000000, 0, 0, 12, 0, 4, 0, 0);
    for (int i = 0; i < 5; i++) add_step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) add_step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add_step(1'b1, 1'b0);
    add_step(1'b1, 1'b1);
    add(7'd0, 1'b1, 1'b0, 100, 0, 5, 0, 1);
    add(7'd0, 1'b0, 1'b0, 12, 0, 5, 0, 0);

    tick(3);
    chk("rst.note", note, 0);
    chk("rst.note_valid", note_valid, 0);
    chk("rst.note_on", note_on, 0);
    chk("rst.octave", octave, 4);
    chk("rst.oct_chg", oct_chg, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      key = tbl[i].key;
      btn_up = tbl[i].up;
      btn_down = tbl[i].dn;
      sb.push_back(tbl[i]);
      b_on = on_cnt;
      b_chg = chg_cnt;
      tick(tbl[i].hold);
      e = sb.pop_front();
      chk($sformatf("v%0d.note", i), note, e.note);
      chk($sformatf("v%0d.valid", i), note_valid, (e.note != 0) ? 1 : 0);
      chk($sformatf("v%0d.octave", i), octave, e.oct);
      chk($sformatf("v%0d.note_on", i), on_cnt - b_on, e.ons);
      chk($sformatf("v%0d.oct_chg", i), chg_cnt - b_chg, e.chgs);
    end

    key = 7'b0000100;
    tick(6);
    chk("lat.press_early", note, 0);
    tick(1);
    chk("lat.press_note", note, 3);
    chk("lat.press_on", note_on, 1);
    tick(1);
    chk("lat.on_single", note_on, 0);
    key = 7'b0000000;
    tick(6);
    chk("lat.release_early", note, 3);
    tick(1);
    chk("lat.release_note", note, 0);
    chk("lat.release_on", note_on, 0);

    b_on = on_cnt;
    b_chg = chg_cnt;
    for (int i = 0; i < 8; i++) begin
      key = 7'b0000001;
      tick(2);
      key = 7'b0000000;
      tick(2);
    end
    tick(8);
    chk("bounce.note", note, 0);
    chk("bounce.note_on", on_cnt - b_on, 0);
    chk("bounce.oct_chg", chg_cnt - b_chg, 0);
    key = 7'b0000001;
    tick(10);
    chk("bounce.hold_note", note, 1);
    chk("bounce.hold_on", on_cnt - b_on, 1);
    key = 7'b0000000;
    tick(10);

    key = 7'b1000000;
    btn_up = 1'b1;
    tick(10);
    btn_up = 1'b0;
    tick(10);
    chk("mid.note", note, 7);
    chk("mid.octave", octave, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.rst_note", note, 0);
    chk("mid.rst_valid", note_valid, 0);
    chk("mid.rst_note_on", note_on, 0);
    chk("mid.rst_octave", octave, 4);
    chk("mid.rst_oct_chg", oct_chg, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("mid.rel_early", note, 0);
    tick(1);
    chk("mid.rel_note", note, 7);
    chk("mid.rel_on", note_on, 1);
    chk("mid.rel_octave", octave, 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
